// File: rtl/aes_pkg.sv
// Shared AES SubBytes constants: forward/inverse S-boxes, block size and engine state type.
package aes_pkg;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Index 0 sits in the leftmost byte so the tables read in textbook row order.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction
endpackage

// File: rtl/aes_sub_bytes_engine_if.sv
// Input/output valid-ready channels of the SubBytes engine.
interface aes_sub_bytes_engine_if;
  import aes_pkg::*;
  logic                           in_valid;
  logic                           in_ready;
  logic [AES_BLOCK_BYTES*8-1:0]   in_data;
  logic                           in_inv;
  logic                           out_valid;
  logic                           out_ready;
  logic [AES_BLOCK_BYTES*8-1:0]   out_data;

  modport slave  (input  in_valid, in_data, in_inv, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, in_inv, out_ready,
                  input  in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: forward or inverse byte substitution.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  assign dout = sbox(din, inv);
endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Iterative SubBytes/InvSubBytes over a 128-bit state, LANES bytes per clock.
module aes_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  aes_sub_bytes_engine_if.slave    bus,
  output logic                     busy
);
  localparam int NBEATS = AES_BLOCK_BYTES / LANES;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e                            state_q, state_d;
  logic [CW-1:0]                     cnt_q;
  logic                              inv_q;
  logic [AES_BLOCK_BYTES-1:0][7:0]   work_q;
  logic [LANES-1:0][7:0]             lane_in, lane_out;
  logic [3:0]                        base;
  logic                              accept, last_beat;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_beat = (cnt_q == CW'(NBEATS - 1));
  assign base      = 4'(int'(cnt_q) * LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = work_q[base + 4'(l)];
    aes_sbox_lane u_lane (.din(lane_in[l]), .inv(inv_q), .dout(lane_out[l]));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_beat)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
  end

  // Substitution happens in place; bytes outside the current beat are untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      work_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      inv_q  <= bus.in_inv;
      work_q <= bus.in_data;
    end else if (state_q == BUSY) begin
      for (int l = 0; l < LANES; l++) work_q[base + 4'(l)] <= lane_out[l];
      if (!last_beat) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_data = work_q;
endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Directed checks on a LANES=4 engine plus a forward/inverse round-trip sweep over all LANES values.
module tb_aes_sub_bytes_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  aes_sub_bytes_engine_if bus ();
  aes_sub_bytes_engine #(.LANES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

  localparam int LT [5] = '{1, 2, 4, 8, 16};
  logic         sw_valid = 1'b0;
  logic         sw_inv = 1'b0;
  logic         sw_ready = 1'b0;
  logic [127:0] sw_din [5];
  logic [127:0] sw_dout [5];
  logic [4:0]   sw_ov;
  logic [4:0]   sw_busy;
  int           sw_lat [5];

  for (genvar g = 0; g < 5; g++) begin : g_sw
    aes_sub_bytes_engine_if sif ();
    assign sif.in_valid  = sw_valid;
    assign sif.in_inv    = sw_inv;
    assign sif.in_data   = sw_din[g];
    assign sif.out_ready = sw_ready;
    assign sw_ov[g]      = sif.out_valid;
    assign sw_dout[g]    = sif.out_data;
    aes_sub_bytes_engine #(.LANES(LT[g])) u_eng (.clk(clk), .rst_n(rst_n), .bus(sif), .busy(sw_busy[g]));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Accepts one block, scrambles the inputs afterwards, and waits (bounded) for out_valid.
  task automatic run_block(input logic [127:0] d, input logic inv, output logic [127:0] res, output int lat);
    @(negedge clk);
    bus.in_data = d; bus.in_inv = inv; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_inv = ~inv; bus.in_data = ~d;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_data;
  endtask

  task automatic handoff();
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
  endtask

  task automatic sw_pass(input logic inv);
    @(negedge clk); sw_inv = inv; sw_valid = 1'b1;
    @(posedge clk); #1; sw_valid = 1'b0; sw_inv = ~inv;
    for (int k = 0; k < 5; k++) sw_lat[k] = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) if (sw_ov[k] && sw_lat[k] == 0) sw_lat[k] = c;
    end
  endtask

  task automatic sw_handoff();
    @(negedge clk); sw_ready = 1'b1;
    @(posedge clk); #1; sw_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] res, x;
    logic [127:0] y [5];
    logic         seen;
    int           lat;
    bus.in_valid = 1'b0; bus.in_inv = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) sw_din[k] = '0;

    // Reset state
    #12;
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy",      128'(busy),          128'd0);
    chk("rst_out_data",  bus.out_data,        128'd0);
    @(negedge clk); rst_n = 1'b1;

    // Forward of all zeros
    run_block(128'd0, 1'b0, res, lat);
    chk("fwd0_lat",      128'(lat), 128'd4);
    chk("fwd0_data",     res, {16{8'h63}});
    chk("fwd0_in_ready", 128'(bus.in_ready), 128'd0);
    chk("fwd0_busy",     128'(busy), 128'd1);
    handoff();
    chk("fwd0_ov_drop",  128'(bus.out_valid), 128'd0);
    chk("fwd0_idle_rdy", 128'(bus.in_ready), 128'd1);

    // Inverse of 00..0f
    run_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b1, res, lat);
    chk("inv_seq_lat",  128'(lat), 128'd4);
    chk("inv_seq_data", res, 128'hfbd7f3819ea340bf38a53630d56a0952);
    handoff();

    // Inverse of all 0x63, forward with boundary bytes
    run_block({16{8'h63}}, 1'b1, res, lat);
    chk("inv63_data", res, 128'd0);
    handoff();
    run_block(128'hff010101010101010101010101010153, 1'b0, res, lat);
    chk("fwd_edge_data", res, 128'h167c7c7c7c7c7c7c7c7c7c7c7c7c7ced);
    handoff();

    // Backpressure: result held, in_valid ignored while DONE
    run_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b0, res, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0]; bus.in_data = {4{$urandom}}; bus.in_inv = i[1];
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_out_data",  bus.out_data, 128'h76abd7fe2b670130c56f6bf27b777c63);
    end
    bus.in_valid = 1'b0;
    handoff();
    chk("bp_ov_drop",   128'(bus.out_valid), 128'd0);
    chk("bp_idle_rdy",  128'(bus.in_ready), 128'd1);
    chk("bp_data_hold", bus.out_data, 128'h76abd7fe2b670130c56f6bf27b777c63);

    // Reset during beat 2
    @(negedge clk);
    bus.in_data = 128'h0123456789abcdef0123456789abcdef; bus.in_inv = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    chk("busy_state_rdy",  128'(bus.in_ready), 128'd0);
    chk("busy_state_busy", 128'(busy), 128'd1);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mrst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("mrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mrst_busy",      128'(busy),          128'd0);
    chk("mrst_out_data",  bus.out_data,        128'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    chk("mrst_no_ov", 128'(seen), 128'd0);
    run_block(128'hff010101010101010101010101010153, 1'b0, res, lat);
    chk("post_rst_lat",  128'(lat), 128'd4);
    chk("post_rst_data", res, 128'h167c7c7c7c7c7c7c7c7c7c7c7c7c7ced);
    handoff();

    // Round-trip sweep across every legal lane count
    for (int b = 0; b < 1000; b++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 5; k++) sw_din[k] = x;
      sw_pass(1'b0);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("sw_fwd_lat_L%0d", LT[k]), 128'(sw_lat[k]), 128'(16 / LT[k]));
        y[k] = sw_dout[k];
      end
      sw_handoff();
      for (int k = 0; k < 5; k++) sw_din[k] = y[k];
      sw_pass(1'b1);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("sw_inv_lat_L%0d", LT[k]), 128'(sw_lat[k]), 128'(16 / LT[k]));
        chk($sformatf("sw_trip_L%0d", LT[k]), sw_dout[k], x);
      end
      sw_handoff();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
